// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer: architectural PC with sequential fetch, branch/jump redirect and a one-cycle flush.
// Optional feature macro BRANCH_STATS_EN adds saturating branch_count / taken_count outputs.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_fetch_valid;
  logic        r_flush;
  logic        w_fetch_valid_nxt;
  logic        w_flush_nxt;
  logic        w_take;
  logic [31:0] w_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;

  // Word offset to byte offset with full sign extension; result is always word aligned.
  function automatic logic [31:0] f_word_offset(input logic [15:0] imm);
    f_word_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

  assign w_take       = branch_valid & branch_taken;
  assign w_pc4        = branch_pc + 32'd4;
  assign w_br_target  = w_pc4 + f_word_offset(branch_imm);
  assign w_jmp_target = {w_pc4[31:28], jump_target, 2'b00};

  // Next-state and next-output logic; a taken branch outranks a jump, and both outrank stall/handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_take) begin
          w_pc_nxt    = w_br_target;
          w_state_nxt = S_FLUSH;
        end else if (jump) begin
          w_pc_nxt    = w_jmp_target;
          w_state_nxt = S_FLUSH;
        end else if (stall || !fetch_ready) begin
          w_pc_nxt    = r_pc;
          w_state_nxt = S_RUN;
        end else begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_fetch_valid_nxt = (w_state_nxt == S_RUN);
    w_flush_nxt       = (w_state_nxt == S_FLUSH);
  end

  // State, PC and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC_AL;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_flush       <= w_flush_nxt;
    end
  end

  assign pc          = r_pc;
  assign fetch_valid = r_fetch_valid;
  assign flush       = r_flush;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_taken_count;
  logic [CNT_W-1:0] w_branch_count_nxt;
  logic [CNT_W-1:0] w_taken_count_nxt;

  // Saturating counters; only RUN cycles are counted, so inputs seen in IDLE/FLUSH are ignored.
  always_comb begin
    w_branch_count_nxt = r_branch_count;
    w_taken_count_nxt  = r_taken_count;
    if ((r_state == S_RUN) && branch_valid && (r_branch_count != {CNT_W{1'b1}})) begin
      w_branch_count_nxt = r_branch_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_branch_count_nxt = r_branch_count;
    end
    if ((r_state == S_RUN) && w_take && (r_taken_count != {CNT_W{1'b1}})) begin
      w_taken_count_nxt = r_taken_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_taken_count_nxt = r_taken_count;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_count <= {CNT_W{1'b0}};
      r_taken_count  <= {CNT_W{1'b0}};
    end else begin
      r_branch_count <= w_branch_count_nxt;
      r_taken_count  <= w_taken_count_nxt;
    end
  end

  assign branch_count = r_branch_count;
  assign taken_count  = r_taken_count;
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: directed scenarios plus randomized traffic
// checked against a cycle-level reference model.
module tb_branch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, fetch_ready, branch_valid, branch_taken, jump;
  logic [31:0] branch_pc;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;
  logic [31:0] pc, pc2;
  logic        fetch_valid, flush, fv2, fl2;
`ifdef BRANCH_STATS_EN
  logic [15:0] bc, tc;
  logic [1:0]  bc2, tc2;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_fv, m_flush, m_idle;
  int          m_bc, m_tc;

  always #5 clk = ~clk;

  branch_pc_sequencer #(
    .RESET_PC(32'h0000_0000)
`ifdef BRANCH_STATS_EN
    , .CNT_W(16)
`endif
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
    .branch_valid(branch_valid), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush)
`ifdef BRANCH_STATS_EN
    , .branch_count(bc), .taken_count(tc)
`endif
  );

  branch_pc_sequencer #(
    .RESET_PC(32'hFFFF_FFFF)
`ifdef BRANCH_STATS_EN
    , .CNT_W(2)
`endif
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
    .branch_valid(branch_valid), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target),
    .pc(pc2), .fetch_valid(fv2), .flush(fl2)
`ifdef BRANCH_STATS_EN
    , .branch_count(bc2), .taken_count(tc2)
`endif
  );

  task automatic clear_inputs();
    stall = 1'b0; fetch_ready = 1'b1; branch_valid = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; branch_pc = 32'h0; branch_imm = 16'h0; jump_target = 26'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_pc = 32'h0; m_fv = 1'b0; m_flush = 1'b0; m_idle = 1'b1; m_bc = 0; m_tc = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Advance one clock and move the model forward using the inputs presented before the edge.
  task automatic tick();
    logic [31:0] n_pc;
    logic        n_fv, n_fl;
    int          n_bc, n_tc;
    n_pc = m_pc; n_fv = m_fv; n_fl = m_flush; n_bc = m_bc; n_tc = m_tc;
    if (!rst_n) begin
      n_pc = 32'h0; n_fv = 1'b0; n_fl = 1'b0;
    end else if (m_idle || m_flush) begin
      n_fv = 1'b1; n_fl = 1'b0;
    end else begin
      if (branch_valid && n_bc < 65535) n_bc = n_bc + 1;
      if (branch_valid && branch_taken && n_tc < 65535) n_tc = n_tc + 1;
      if (branch_valid && branch_taken) begin
        n_pc = branch_pc + 32'd4 + 32'(int'($signed(branch_imm)) * 4);
        n_fv = 1'b0; n_fl = 1'b1;
      end else if (jump) begin
        n_pc = ((branch_pc + 32'd4) & 32'hF000_0000) | (32'(jump_target) * 32'd4);
        n_fv = 1'b0; n_fl = 1'b1;
      end else if (!stall && fetch_ready) begin
        n_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) m_idle = 1'b0;
    m_pc = n_pc; m_fv = n_fv; m_flush = n_fl; m_bc = n_bc; m_tc = n_tc;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", fetch_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (pc !== 32'(k * 4) || fetch_valid !== 1'b1 || flush !== 1'b0) begin
        errors++; $display("FAIL startup_seq[%0d] got pc=%h fv=%b fl=%b exp pc=%h fv=1 fl=0", k, pc, fetch_valid, flush, 32'(k * 4));
      end
    end
  endtask

  task automatic test_branch();
    do_reset(); tick();
    branch_valid = 1'b1; branch_taken = 1'b1; branch_pc = 32'h10; branch_imm = 16'h0003;
    tick(); clear_inputs();
    checks++;
    if (pc !== 32'h20 || flush !== 1'b1 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL fwd_branch got pc=%h fl=%b fv=%b exp pc=00000020 fl=1 fv=0", pc, flush, fetch_valid);
    end
    tick();
    checks++;
    if (pc !== 32'h20 || flush !== 1'b0 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL fwd_branch_fetch got pc=%h fl=%b fv=%b exp pc=00000020 fl=0 fv=1", pc, flush, fetch_valid);
    end
    branch_valid = 1'b1; branch_taken = 1'b0; branch_pc = 32'h10; branch_imm = 16'h0003;
    tick(); clear_inputs();
    checks++;
    if (pc !== 32'h24 || flush !== 1'b0 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL not_taken got pc=%h fl=%b exp pc=00000024 fl=0", pc, flush);
    end
  endtask

  task automatic test_backward();
    do_reset(); tick();
    branch_valid = 1'b1; branch_taken = 1'b1; branch_pc = 32'h10; branch_imm = 16'hFFFF;
    tick(); clear_inputs();
    checks++;
    if (pc !== 32'h10 || flush !== 1'b1) begin
      errors++; $display("FAIL back_branch got pc=%h fl=%b exp pc=00000010 fl=1", pc, flush);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if (pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset got %h exp fffffffc", pc2); end
    tick();
    checks++; if (pc2 !== 32'hFFFF_FFFC || fv2 !== 1'b1) begin errors++; $display("FAIL wrap_first got pc=%h fv=%b exp fffffffc 1", pc2, fv2); end
    tick();
    checks++; if (pc2 !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 00000000", pc2); end
    tick();
    checks++; if (pc2 !== 32'h4) begin errors++; $display("FAIL wrap_four got %h exp 00000004", pc2); end
  endtask

  task automatic test_jump();
    do_reset(); tick();
    jump = 1'b1; branch_pc = 32'h40; jump_target = 26'h100;
    tick(); clear_inputs();
    checks++;
    if (pc !== 32'h400 || flush !== 1'b1) begin
      errors++; $display("FAIL jump got pc=%h fl=%b exp pc=00000400 fl=1", pc, flush);
    end
    tick();
    branch_valid = 1'b1; branch_taken = 1'b1; branch_pc = 32'h10; branch_imm = 16'h0003;
    jump = 1'b1; jump_target = 26'h100;
    tick(); clear_inputs();
    checks++;
    if (pc !== 32'h20 || flush !== 1'b1) begin
      errors++; $display("FAIL priority got pc=%h fl=%b exp pc=00000020 fl=1", pc, flush);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_setup got %h exp 00000008", pc); end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_hold[%0d] got %h exp 00000008", k, pc); end
    end
    stall = 1'b0; fetch_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL not_ready_hold[%0d] got %h exp 00000008", k, pc); end
    end
    fetch_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL stall_release got %h exp 0000000c", pc); end
    stall = 1'b1; fetch_ready = 1'b0;
    branch_valid = 1'b1; branch_taken = 1'b1; branch_pc = 32'h10; branch_imm = 16'h0003;
    tick(); clear_inputs();
    checks++;
    if (pc !== 32'h20 || flush !== 1'b1) begin
      errors++; $display("FAIL stall_redirect got pc=%h fl=%b exp pc=00000020 fl=1", pc, flush);
    end
    tick();
  endtask

  task automatic test_flush_ignore();
    do_reset(); tick();
    branch_valid = 1'b1; branch_taken = 1'b1; branch_pc = 32'h10; branch_imm = 16'h0003;
    tick();
    jump = 1'b1; jump_target = 26'h3FF; branch_pc = 32'h100; stall = 1'b1;
    tick(); clear_inputs();
    checks++;
    if (pc !== 32'h20 || flush !== 1'b0 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL flush_ignore got pc=%h fl=%b fv=%b exp pc=00000020 fl=0 fv=1", pc, flush, fetch_valid);
    end
  endtask

  task automatic test_reset_in_flush();
    do_reset(); tick();
    branch_valid = 1'b1; branch_taken = 1'b1; branch_pc = 32'h10; branch_imm = 16'h0003;
    tick(); clear_inputs();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rif_setup got fl=%b exp 1", flush); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || flush !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL reset_in_flush got pc=%h fl=%b fv=%b exp 00000000 0 0", pc, flush, fetch_valid);
    end
    do_reset();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    do_reset(); tick();
    for (int i = 0; i < 5; i++) begin
      branch_valid = 1'b1; branch_taken = (i < 3); branch_pc = 32'h10; branch_imm = 16'h0003;
      tick();
      if (i < 3) tick();
      clear_inputs();
    end
    checks++; if (bc !== 16'd5 || 32'(bc) !== 32'(m_bc)) begin errors++; $display("FAIL stats_branch got %0d exp 5", bc); end
    checks++; if (tc !== 16'd3) begin errors++; $display("FAIL stats_taken got %0d exp 3", tc); end
    branch_valid = 1'b1; branch_taken = 1'b0;
    tick(); clear_inputs();
    checks++; if (bc2 !== 2'd3 || tc2 !== 2'd3) begin errors++; $display("FAIL stats_saturate got %0d/%0d exp 3/3", bc2, tc2); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      stall        = ($urandom % 4) == 0;
      fetch_ready  = ($urandom % 4) != 0;
      branch_valid = ($urandom % 3) == 0;
      branch_taken = $urandom % 2;
      jump         = ($urandom % 6) == 0;
      branch_pc    = {$urandom, 2'b00};
      branch_imm   = 16'($urandom);
      jump_target  = 26'($urandom);
      tick();
      checks++;
      if (pc !== m_pc || fetch_valid !== m_fv || flush !== m_flush) begin
        errors++; $display("FAIL random[%0d] got pc=%h fv=%b fl=%b exp pc=%h fv=%b fl=%b", n, pc, fetch_valid, flush, m_pc, m_fv, m_flush);
      end
`ifdef BRANCH_STATS_EN
      checks++;
      if (32'(bc) !== 32'(m_bc) || 32'(tc) !== 32'(m_tc)) begin
        errors++; $display("FAIL random_stats[%0d] got %0d/%0d exp %0d/%0d", n, bc, tc, m_bc, m_tc);
      end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_branch();
    test_backward();
    test_wrap();
    test_jump();
    test_stall();
    test_flush_ignore();
    test_reset_in_flush();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
